// File: rtl/fetch_queue.sv
// fetch_queue: decoupling FIFO between instruction fetch and decode.
// Each accepted {pc, instr} pair is held in a small circular buffer, and the
// oldest entry is presented to decode first-word-fall-through. Fetch sees
// back-pressure when the buffer is full, and a redirect (flush) empties it.
module fetch_queue #(
  parameter int                 DEPTH     = 4,
  parameter int                 PC_W      = 64,
  parameter int                 INSTR_W   = 32,
  parameter logic [INSTR_W-1:0] NOP_INSTR = 32'h00000013
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [PC_W-1:0]          in_pc,
  input  logic [INSTR_W-1:0]       in_instr,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [PC_W-1:0]          out_pc,
  output logic [INSTR_W-1:0]       out_instr,
  input  logic                     out_ready,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int            AW       = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

  logic [PC_W-1:0]    pc_mem    [DEPTH];
  logic [INSTR_W-1:0] instr_mem [DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic               push;
  logic               pop;

  // Handshake flags depend on occupancy only; a same-cycle pop does not
  // open a slot for fetch until the following cycle.
  assign in_ready  = (count != FULL_CNT);
  assign out_valid = (count != '0);

  // A redirect takes priority over any transfer in the same cycle.
  assign push = in_valid & in_ready & ~flush;
  assign pop  = out_valid & out_ready & ~flush;

  // Head entry falls through; an empty queue shows a harmless NOP at PC 0.
  assign out_pc    = out_valid ? pc_mem[rd_ptr]    : '0;
  assign out_instr = out_valid ? instr_mem[rd_ptr] : NOP_INSTR;

  // Storage is written only on an accepted push and needs no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]    <= in_pc;
      instr_mem[wr_ptr] <= in_instr;
    end
  end

  // Pointer and occupancy tracking; pointers wrap naturally at a power-of-2 depth.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Decoupling buffer between the instruction memory stage and decode.
- Captures each fetched {PC, instruction} pair into a small circular FIFO and presents the oldest entry to decode with a valid/ready handshake.
- Back-pressures fetch when full; the fetch PC-update logic gates its next-PC step on in_ready.
- Discards all contents on a branch/jump redirect.

Parameters:
DEPTH, 4, number of entries; power of 2, minimum 2
PC_W, 64, program counter width
INSTR_W, 32, instruction width
NOP_INSTR, 32'h00000013, value driven on out_instr while empty

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  fetch presents a valid pair this cycle
in_pc  input  PC_W  PC of the fetched instruction
in_instr  input  INSTR_W  fetched instruction word
in_ready  output  1  queue can accept a pair this cycle
out_valid  output  1  head entry valid for decode
out_pc  output  PC_W  PC of head entry
out_instr  output  INSTR_W  instruction of head entry
out_ready  input  1  decode consumes head this cycle
flush  input  1  redirect; discard all entries
count  output  log2(DEPTH)+1  current occupancy

Behaviour:
- State: storage array DEPTH x (PC_W+INSTR_W), wr_ptr/rd_ptr of log2(DEPTH) bits, count register.
- Reset (rst=1, asynchronous, at any time including mid-transfer): wr_ptr=0, rd_ptr=0, count=0. Storage contents are don't-care.
- Outputs during and after reset: out_valid=0, in_ready=1, out_pc=0, out_instr=NOP_INSTR, count=0.
- in_ready = (count != DEPTH), combinational from count only. There is no same-cycle bypass from out_ready.
- out_valid = (count != 0).
- out_pc/out_instr: first-word fall-through from storage[rd_ptr] when out_valid=1. When empty, they are forced to 0 and NOP_INSTR.
- push = in_valid & in_ready & ~flush. It writes storage[wr_ptr] and advances wr_ptr by 1, wrapping DEPTH-1 -> 0.
- pop = out_valid & out_ready & ~flush. It advances rd_ptr by 1 with the same wrap.
- Count update:
  - push only: count+1.
  - pop only: count-1.
  - push and pop together: count unchanged, both pointers advance.
- Latency:
  - An entry pushed at edge N is visible on the outputs in the cycle after edge N.
  - Minimum fetch-to-decode latency is 1 cycle.
  - Throughput is 1 entry/cycle when out_ready is held high.
- Full: in_ready=0 and in_valid is ignored. Fetch must hold its PC. Data is neither lost nor overwritten.
  - A pop in a full cycle frees a slot for the next cycle only.
- Empty: out_valid=0 and out_ready is ignored. No underflow occurs, and rd_ptr does not move.
- Flush:
  - At the next edge, count=0 and rd_ptr=wr_ptr=0.
  - Any same-cycle push or pop is dropped, so flush has priority.
  - The first post-flush push lands in entry 0.
  - Flush during reset has no additional effect.
- Inputs on a cycle where push=0 must not modify storage.
- in_pc and in_instr are stored unmodified. No alignment or PC checks are performed here.

Test Plan:
- Reset check: assert rst for 3 cycles with in_valid=1 -> out_valid=0, in_ready=1, count=0, out_instr=32'h00000013, out_pc=0. Release rst -> the first push appears the next cycle.
- Fill and drain: out_ready=0; push PC=0xA,0xE,0x12,0x16 with instr 0x00500093,0x00A00113,0x002081B3,0x40208233 -> count=4, in_ready=0. A fifth push with PC=0x1A is ignored. Then out_ready=1 -> the four pairs emerge in order over 4 cycles, then out_valid=0.
- Simultaneous push/pop while full: count=4, in_valid=1 (PC=0x1A), out_ready=1 -> push blocked, head 0xA popped, count=3. Next cycle 0x1A is accepted and count=4.
- Wrap-around: push/pop continuously for 10 entries with out_ready=1 -> PCs emerge 0xA..0x2E (step 4) in order, count stays 1 throughout, and pointers wrap twice with no loss.
- Flush: count=3 with a concurrent push and pop -> next cycle count=0, out_valid=0, out_instr=0x00000013. The next push (PC=0x100) is output at the head the following cycle.
- Reset mid-operation: count=2, then rst pulsed asynchronously between clock edges -> outputs go to reset values immediately, with no edge required. After release, stale entries never reappear.
